// File: rtl/lcd_resize_pkg.sv
// Geometry defaults and fetch-FSM encoding shared by the LCD resize path
// (scaler here, frame writer on the SDRAM side).
package lcd_resize_pkg;
  localparam int SRC_W_DEF  = 400;
  localparam int SRC_H_DEF  = 240;
  localparam int DST_W_DEF  = 800;
  localparam int DST_H_DEF  = 480;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FULL
  } fetch_st_e;
endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line RAM: one write port, one registered read port that
// holds its last word while the read enable is low.
module line_buf_dp #(
  parameter int DEPTH  = 800,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)     rd_q <= '0;
    else if (re_i) rd_q <= mem_q[raddr_i];

  assign rdata_o = rd_q;
endmodule

// File: rtl/lcd_nn_scaler.sv
// Nearest-neighbour upscaler: ping-pong line fetch from the read FIFO and
// DDA-driven horizontal/vertical pixel replication toward the LCD driver.
module lcd_nn_scaler
  import lcd_resize_pkg::*;
#(
  parameter int SRC_W  = SRC_W_DEF,
  parameter int SRC_H  = SRC_H_DEF,
  parameter int DST_W  = DST_W_DEF,
  parameter int DST_H  = DST_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              data_req,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] pixel_data,
  output logic              underrun
);
  localparam int XW  = $clog2(SRC_W + 1);
  localparam int OXW = $clog2(DST_W + 1);
  localparam int YW  = $clog2(SRC_H + 1);
  localparam int OYW = $clog2(DST_H + 1);
  localparam int HAW = $clog2(2 * DST_W);
  localparam int VAW = $clog2(2 * DST_H);
  localparam int AW  = $clog2(2 * SRC_W);

  fetch_st_e        state_q;
  logic             fetch_req_q, primed_q, rd_vld_q, disp_bank_q, underrun_q, swap_pend_q;
  logic [YW-1:0]    lines_q;
  logic [XW-1:0]    wr_x_q, rd_cnt_q, src_x_q;
  logic [OXW-1:0]   out_x_q;
  logic [OYW-1:0]   out_y_q;
  logic [HAW-1:0]   h_acc_q, h_sum, h_acc_d;
  logic [VAW-1:0]   v_acc_q, v_sum, v_acc_d;
  logic             h_step, v_step, fetch_bank, wr_en, wr_last;
  logic             rd_go, line_end, want_swap, full_now, do_swap;
  logic [AW-1:0]    wr_addr, rd_addr;

  // Line 0 is loaded into the display bank itself; afterwards fetches go to the other bank.
  assign fetch_bank = primed_q ? ~disp_bank_q : disp_bank_q;
  assign fifo_rd_en = (state_q == ST_FETCH) && !fifo_empty && !frame_start
                      && (rd_cnt_q < XW'(SRC_W));
  assign wr_en      = rd_vld_q && (state_q == ST_FETCH) && !frame_start;
  assign wr_last    = wr_en && (wr_x_q == XW'(SRC_W - 1));

  assign rd_go      = data_req && !frame_start && (out_y_q != OYW'(DST_H));
  assign line_end   = rd_go && (out_x_q == OXW'(DST_W - 1));
  assign h_sum      = h_acc_q + HAW'(SRC_W);
  assign h_step     = h_sum >= HAW'(DST_W);
  assign h_acc_d    = h_step ? h_sum - HAW'(DST_W) : h_sum;
  assign v_sum      = v_acc_q + VAW'(SRC_H);
  assign v_step     = v_sum >= VAW'(DST_H);
  assign v_acc_d    = v_step ? v_sum - VAW'(DST_H) : v_sum;

  // The advance on the frame's last line has no successor line to swap in.
  assign want_swap  = line_end && (out_y_q != OYW'(DST_H - 1)) && (v_step || swap_pend_q);
  assign full_now   = (state_q == ST_FULL) || (wr_last && primed_q);
  assign do_swap    = want_swap && full_now;

  assign wr_addr    = fetch_bank  ? AW'(SRC_W) + AW'(wr_x_q)  : AW'(wr_x_q);
  assign rd_addr    = disp_bank_q ? AW'(SRC_W) + AW'(src_x_q) : AW'(src_x_q);
  assign underrun   = underrun_q;

  always_ff @(posedge lcd_pclk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      fetch_req_q <= 1'b0;
      primed_q    <= 1'b0;
      lines_q     <= '0;
      wr_x_q      <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
    end else if (frame_start) begin
      state_q     <= ST_IDLE;
      fetch_req_q <= 1'b1;
      primed_q    <= 1'b0;
      lines_q     <= '0;
      wr_x_q      <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      rd_vld_q <= fifo_rd_en;
      if (fifo_rd_en) rd_cnt_q <= rd_cnt_q + XW'(1);
      if (wr_en)      wr_x_q   <= wr_x_q + XW'(1);
      case (state_q)
        ST_IDLE:
          if (fetch_req_q && (lines_q < YW'(SRC_H))) begin
            state_q     <= ST_FETCH;
            fetch_req_q <= 1'b0;
            wr_x_q      <= '0;
            rd_cnt_q    <= '0;
          end
        ST_FETCH:
          if (wr_last) begin
            lines_q  <= lines_q + YW'(1);
            wr_x_q   <= '0;
            rd_cnt_q <= '0;
            if (!primed_q) begin
              primed_q <= 1'b1;
              state_q  <= ((lines_q + YW'(1)) < YW'(SRC_H)) ? ST_FETCH : ST_IDLE;
            end else if (do_swap) begin
              state_q     <= ST_IDLE;
              fetch_req_q <= 1'b1;
            end else begin
              state_q <= ST_FULL;
            end
          end
        ST_FULL:
          if (do_swap) begin
            state_q     <= ST_IDLE;
            fetch_req_q <= 1'b1;
          end
        default: state_q <= ST_IDLE;
      endcase
    end

  // Out of reset the frame counts as finished, so stray requests read nothing.
  always_ff @(posedge lcd_pclk or posedge rst)
    if (rst) begin
      src_x_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= OYW'(DST_H);
      h_acc_q     <= '0;
      v_acc_q     <= '0;
      disp_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (frame_start) begin
      src_x_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      h_acc_q     <= '0;
      v_acc_q     <= '0;
      disp_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (rd_go) begin
      if (line_end) begin
        out_x_q <= '0;
        src_x_q <= '0;
        h_acc_q <= '0;
        out_y_q <= out_y_q + OYW'(1);
        v_acc_q <= v_acc_d;
        if (do_swap) begin
          disp_bank_q <= ~disp_bank_q;
          swap_pend_q <= 1'b0;
        end else if (want_swap) begin
          underrun_q  <= 1'b1;
          swap_pend_q <= 1'b1;
        end
      end else begin
        out_x_q <= out_x_q + OXW'(1);
        h_acc_q <= h_acc_d;
        if (h_step) src_x_q <= src_x_q + XW'(1);
      end
    end

  line_buf_dp #(
    .DEPTH (2 * SRC_W),
    .DATA_W(DATA_W)
  ) u_lbuf (
    .clk_i  (lcd_pclk),
    .rst_i  (rst),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(fifo_rd_data),
    .re_i   (rd_go),
    .raddr_i(rd_addr),
    .rdata_o(pixel_data)
  );
endmodule

// File: tb/tb_lcd_nn_scaler.sv
// Bench for lcd_nn_scaler at 4x2 -> 8x4: FIFO model, ideal-mapping pixel model
// and a per-cycle compare process, plus directed underrun/abort/reset cases.
module tb_lcd_nn_scaler;
  localparam int SRC_W = 4;
  localparam int SRC_H = 2;
  localparam int DST_W = 8;
  localparam int DST_H = 4;
  localparam int DATA_W = 16;

  logic              clk, rst, frame_start, data_req, fifo_empty, fifo_rd_en, underrun;
  logic [DATA_W-1:0] fifo_rd_data, pixel_data;

  logic [15:0] fmem [0:255];
  int          wp, rp;
  logic        stall_en, stall_tog;
  logic [15:0] exp_mem [0:1023];
  int          ew, er;
  int          rd_total;
  int          n_chk, n_pass;
  logic [15:0] last_exp;

  lcd_nn_scaler #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H), .DATA_W(DATA_W)
  ) dut (
    .lcd_pclk    (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .data_req    (data_req),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .pixel_data  (pixel_data),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode FIFO; the frame writer flushes it on frame_start.
  assign fifo_empty = stall_tog || (rp == wp);
  initial begin
    rp = 0;
    fifo_rd_data = '0;
  end
  always @(posedge clk)
    if (frame_start) rp <= wp;
    else if (fifo_rd_en && rp != wp) begin
      fifo_rd_data <= fmem[rp];
      rp <= rp + 1;
    end

  initial begin
    stall_tog = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall_tog = stall_en ? !stall_tog : 1'b0;
    end
  end

  function automatic logic [15:0] pix(input int tag, input int l, input int x);
    return 16'((tag << 8) | (l << 4) | x);
  endfunction

  // Ideal nearest-neighbour pick: output column ox shows source column floor(ox*SRC_W/DST_W).
  function automatic logic [15:0] model(input int tag, input int sl, input int ox);
    return pix(tag, sl, (ox * SRC_W) / DST_W);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int tag, input int l);
    for (int x = 0; x < SRC_W; x++) begin
      fmem[wp] = pix(tag, l, x);
      wp++;
    end
  endtask

  task automatic start_frame(input int tag, input int nlines);
    frame_start = 1'b1;
    sync();
    frame_start = 1'b0;
    for (int l = 0; l < nlines; l++) push_line(tag, l);
  endtask

  task automatic req_line(input int tag, input int sl, input int gap_at, input int n);
    for (int ox = 0; ox < n; ox++) begin
      if (ox == gap_at) begin
        data_req = 1'b0;
        repeat (3) sync();
      end
      data_req = 1'b1;
      exp_mem[ew] = model(tag, sl, ox);
      ew++;
      sync();
    end
    data_req = 1'b0;
  endtask

  // Compare process: every cycle, pixel_data must equal the model's value for the
  // request of the previous edge, or hold its last value when there was none.
  initial begin
    logic rq;
    er = 0;
    rd_total = 0;
    last_exp = '0;
    forever begin
      @(posedge clk);
      rq = data_req && !rst;
      if (fifo_rd_en) rd_total++;
      @(negedge clk);
      if (rst) last_exp = '0;
      if (rq) begin
        if (er < ew) begin
          last_exp = exp_mem[er];
          er++;
        end else chk("expect_queue_empty", 1, 0);
        chk("pixel", pixel_data, last_exp);
      end else chk("pixel_hold", pixel_data, last_exp);
      if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    n_chk = 0; n_pass = 0; ew = 0; wp = 0;
    rst = 1'b1; frame_start = 1'b0; data_req = 1'b0; stall_en = 1'b0;
    repeat (3) sync();
    chk("reset_pixel", pixel_data, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_underrun", underrun, 0);
    rst = 1'b0;
    sync();

    // Frame 1: plain mapping, then post-frame requests return the last pixel.
    r0 = rd_total;
    start_frame(1, 2);
    repeat (9) sync();
    req_line(1, 0, -1, DST_W);
    @(negedge clk);
    chk("line0_last_pixel", pixel_data, 16'h0103);
    sync();
    for (int j = 1; j < DST_H; j++) req_line(1, (j * SRC_H) / DST_H, -1, DST_W);
    for (int k = 0; k < 3; k++) begin
      data_req = 1'b1;
      exp_mem[ew] = 16'h0113;
      ew++;
      sync();
    end
    data_req = 1'b0;
    @(negedge clk);
    chk("frame_end_pixel", pixel_data, 16'h0113);
    chk("frame1_reads", rd_total - r0, 8);
    chk("frame1_underrun", underrun, 0);
    sync();

    // Frame 2: FIFO empty every other cycle during the fetches, gaps mid-line.
    r0 = rd_total;
    stall_en = 1'b1;
    start_frame(2, 2);
    repeat (20) sync();
    for (int j = 0; j < DST_H; j++) req_line(2, (j * SRC_H) / DST_H, 3 + (j % 2) * 2, DST_W);
    stall_en = 1'b0;
    sync();
    chk("frame2_reads", rd_total - r0, 8);
    chk("frame2_underrun", underrun, 0);

    // Frame 3: line 1 missing at the swap point -> underrun, line 0 repeats once more.
    start_frame(3, 1);
    repeat (9) sync();
    req_line(3, 0, -1, DST_W);
    req_line(3, 0, -1, DST_W);
    @(negedge clk);
    chk("underrun_set", underrun, 1);
    sync();
    push_line(3, 1);
    repeat (8) sync();
    req_line(3, 0, -1, DST_W);
    req_line(3, 1, -1, DST_W);
    @(negedge clk);
    chk("retry_swap_pixel", pixel_data, 16'h0313);
    sync();

    // Frame 4 is aborted while fetching word 2 of line 1; frame 5 must start clean.
    start_frame(4, 2);
    @(negedge clk);
    chk("underrun_cleared", underrun, 0);
    sync();
    repeat (7) sync();
    r0 = rd_total;
    start_frame(5, 2);
    repeat (9) sync();
    for (int j = 0; j < DST_H; j++) req_line(5, (j * SRC_H) / DST_H, -1, DST_W);
    sync();
    chk("frame5_reads", rd_total - r0, 8);
    chk("frame5_underrun", underrun, 0);

    // Frame 6: async reset in the middle of a line and of a stalled fetch.
    start_frame(6, 1);
    repeat (9) sync();
    req_line(6, 0, -1, 3);
    repeat (2) sync();
    rst = 1'b1;
    #1;
    chk("async_rst_pixel", pixel_data, 0);
    chk("async_rst_rd_en", fifo_rd_en, 0);
    chk("async_rst_underrun", underrun, 0);
    sync();
    rst = 1'b0;
    r0 = rd_total;
    push_line(6, 1);
    repeat (10) sync();
    chk("no_reads_after_rst", rd_total - r0, 0);
    chk("all_requests_checked", er, ew);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
